// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect bubbles and data-memory freezes.
// Optional perf counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW           = 6,
    parameter int unsigned REDIRECT_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              redirect,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events,
    output logic [31:0]       freeze_cycles
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ILLEGAL  = 2'd3;
    localparam logic [1:0] CNT_LOAD    = 2'(REDIRECT_BUBBLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu, fz;

    assign lu    = ex_memread && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign fz    = dmem_req && !dmem_ready;
    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_wb_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_wb_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else begin
            if (fz) begin
                // Counter is held so a frozen FLUSH countdown resumes afterwards.
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                ex_wb_en = 1'b0;
                state_d  = ST_MEM_WAIT;
            end else if (redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                cnt_d       = CNT_LOAD;
                state_d     = (CNT_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                cnt_d       = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                state_d     = (cnt_q <= 2'd1) ? ST_RUN : ST_FLUSH;
            end else begin
                if (lu) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                state_d = (cnt_q != 2'd0) ? ST_FLUSH : ST_RUN;
            end
            if (state_q == ST_ILLEGAL) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;
    logic [31:0] freeze_q, freeze_d;
    logic        lu_stall;

    assign lu_stall = lu && !fz && !redirect && (state_q != ST_FLUSH);

    always_comb begin
        stall_d  = stall_q;
        flush_d  = flush_q;
        freeze_d = freeze_q;
        if ((fz || lu_stall) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
        if (redirect && !fz && (flush_q != 32'hFFFF_FFFF)) flush_d = flush_q + 32'd1;
        if (fz && (freeze_q != 32'hFFFF_FFFF)) freeze_d = freeze_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            freeze_q <= freeze_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign flush_events  = flush_q;
    assign freeze_cycles = freeze_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Vector-table bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=3) with a scoreboard queue.
module tb_pipe_hazard_ctrl;

    // {pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush}
    localparam logic [5:0] C_RUN   = 6'b1111_00;
    localparam logic [5:0] C_STALL = 6'b0011_01;
    localparam logic [5:0] C_FLUSH = 6'b1111_11;
    localparam logic [5:0] C_FRZ   = 6'b0000_00;
    localparam logic [5:0] C_RST   = 6'b0000_11;

    typedef struct {
        logic       rst_n;
        logic [5:0] id_rs;
        logic [5:0] id_rt;
        logic       uses_rt;
        logic [5:0] ex_rd;
        logic       memread;
        logic       redirect;
        logic       req;
        logic       ready;
        logic [5:0] ctl;
        logic [1:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rt = 1'b0, ex_memread = 1'b0, redirect = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush;
    logic [1:0] state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events, freeze_cycles;
    int unsigned m_stall = 0, m_flush = 0, m_freeze = 0;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW          (6),
        .REDIRECT_BUBBLES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .redirect   (redirect),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .id_ex_en   (id_ex_en),
        .ex_wb_en   (ex_wb_en),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .state      (state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .freeze_cycles(freeze_cycles)
`endif
    );

    function automatic vec_t mk(input logic r, input logic [5:0] rs, input logic [5:0] rt,
                                input logic ur, input logic [5:0] rd, input logic mr,
                                input logic redir, input logic rq, input logic rdy,
                                input logic [5:0] ctl, input logic [1:0] st);
        vec_t v;
        v.rst_n = r; v.id_rs = rs; v.id_rt = rt; v.uses_rt = ur; v.ex_rd = rd;
        v.memread = mr; v.redirect = redir; v.req = rq; v.ready = rdy;
        v.ctl = ctl; v.st = st;
        return v;
    endfunction

    // Quiet inputs with optional redirect / memory handshake.
    function automatic vec_t qv(input logic r, input logic redir, input logic rq,
                                input logic rdy, input logic [5:0] ctl, input logic [1:0] st);
        return mk(r, 6'd1, 6'd2, 1'b0, 6'd3, 1'b0, redir, rq, rdy, ctl, st);
    endfunction

    // Load-use inputs (ex_rd == id_rs == 5).
    function automatic vec_t luv(input logic redir, input logic rq, input logic rdy,
                                 input logic [5:0] ctl, input logic [1:0] st);
        return mk(1'b1, 6'd5, 6'd2, 1'b0, 6'd5, 1'b1, redir, rq, rdy, ctl, st);
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        logic [5:0] got;
        rst_n = v.rst_n; id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.uses_rt;
        ex_rd = v.ex_rd; ex_memread = v.memread; redirect = v.redirect;
        dmem_req = v.req; dmem_ready = v.ready;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        got = {pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush};
        checks++;
        if (got !== e.ctl || state !== e.st) begin
            errors++;
            $display("FAIL %s: ctl=%b state=%0d, expected ctl=%b state=%0d",
                     name, got, state, e.ctl, e.st);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        if (!e.rst_n) begin
            m_stall = 0; m_flush = 0; m_freeze = 0;
        end else begin
            if (e.ctl == C_STALL || e.ctl == C_FRZ) m_stall++;
            if (e.redirect && e.ctl != C_FRZ) m_flush++;
            if (e.ctl == C_FRZ) m_freeze++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with redirect asserted
        for (int i = 0; i < 3; i++) vecs.push_back(qv(1'b0, 1'b1, 1'b0, 1'b0, C_RST, 2'd0));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0));
        // Load-use decode
        vecs.push_back(luv(1'b0, 1'b0, 1'b0, C_STALL, 2'd0));
        vecs.push_back(mk(1, 6'd5, 6'd2, 0, 6'd6, 1, 0, 0, 0, C_RUN, 2'd0));
        vecs.push_back(mk(1, 6'd0, 6'd5, 0, 6'd5, 1, 0, 0, 0, C_RUN, 2'd0));
        vecs.push_back(mk(1, 6'd0, 6'd5, 1, 6'd5, 1, 0, 0, 0, C_STALL, 2'd0));
        vecs.push_back(mk(1, 6'd0, 6'd7, 0, 6'd0, 1, 0, 0, 0, C_STALL, 2'd0));
        // Redirect: three flush cycles, lu suppressed inside FLUSH
        vecs.push_back(qv(1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(luv(1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0));
        // Re-redirect on flush cycle 2 restarts the countdown
        vecs.push_back(qv(1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(qv(1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1));
        vecs.push_back(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Freeze with redirect pending, released on the ready cycle
        apply(qv(1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 2'd0), "freeze0");
        for (int i = 1; i < 4; i++)
            apply(qv(1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 2'd2), $sformatf("freeze%0d", i));
        apply(qv(1'b1, 1'b1, 1'b1, 1'b1, C_FLUSH, 2'd2), "freeze_ready");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "freeze_fl1");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "freeze_fl2");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "freeze_done");

        // Load-use together with redirect: redirect wins
        apply(luv(1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0), "lu_redir");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "lu_redir_fl1");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "lu_redir_fl2");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "lu_redir_done");

        // Freeze inside FLUSH keeps the countdown pending
        apply(qv(1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0), "fzfl_redir");
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd1), "fzfl_frz1");
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd2), "fzfl_frz2");
        apply(qv(1'b1, 1'b0, 1'b1, 1'b1, C_RUN, 2'd2), "fzfl_exit");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "fzfl_fl1");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd1), "fzfl_fl2");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "fzfl_done");

        // Load-use takes effect on the MEM_WAIT exit cycle
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd0), "mwlu_frz");
        apply(luv(1'b0, 1'b1, 1'b1, C_STALL, 2'd2), "mwlu_exit");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "mwlu_done");

        // Reset during freeze and during FLUSH leaves no residue
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd0), "rstfz_frz1");
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd2), "rstfz_frz2");
        apply(qv(1'b0, 1'b0, 1'b1, 1'b0, C_RST, 2'd2), "rstfz_rst");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "rstfz_after");
        apply(qv(1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, 2'd0), "rstfl_redir");
        apply(qv(1'b0, 1'b0, 1'b0, 1'b0, C_RST, 2'd1), "rstfl_rst");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "rstfl_after");

        // MEM_WAIT also exits when the request drops
        apply(qv(1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 2'd0), "reqdrop_frz");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd2), "reqdrop_exit");
        apply(qv(1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0), "reqdrop_done");

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        @(negedge clk);
        checks++;
        if (stall_cycles !== m_stall || flush_events !== m_flush || freeze_cycles !== m_freeze) begin
            errors++;
            $display("FAIL perf: stall=%0d flush=%0d freeze=%0d, expected %0d %0d %0d",
                     stall_cycles, flush_events, freeze_cycles, m_stall, m_flush, m_freeze);
        end
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
